// File: rtl/pipeline_pkg.sv
// Shared types and constants for the pipeline control unit and its forwarding comparators.
package pipeline_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } pcu_state_t;

  // Operand source selects for the EX-stage SrcA/SrcB muxes.
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // R15 reads return the PC, so they never take a forwarded value.
  localparam logic [3:0] REG_PC = 4'hF;

endpackage

// File: rtl/hazard_fwd_cmp.sv
// Forwarding select for one EX operand: MEM result beats WB result, the PC is never forwarded.
module hazard_fwd_cmp
  import pipeline_pkg::*;
(
  input  logic       en_i,
  input  logic [3:0] ra_e_i,
  input  logic [3:0] wa3_m_i,
  input  logic [3:0] wa3_w_i,
  input  logic       reg_write_m_i,
  input  logic       reg_write_w_i,
  output logic [1:0] fwd_o
);

  always_comb begin
    fwd_o = FWD_RF;
    if (en_i && (ra_e_i != REG_PC)) begin
      if (reg_write_m_i && (wa3_m_i == ra_e_i)) begin
        fwd_o = FWD_MEM;
      end else if (reg_write_w_i && (wa3_w_i == ra_e_i)) begin
        fwd_o = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/pipeline_control_unit.sv
// Run sequencer and hazard unit for the 5-stage pipeline: forwarding, load-use stalls,
// control-hazard flushes, halt drain, and saturating cycle/stall counters.
module pipeline_control_unit
  import pipeline_pkg::*;
#(
  parameter int CNT_W        = 32,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       RA1D,
  input  logic [3:0]       RA2D,
  input  logic [3:0]       WA3E,
  input  logic [3:0]       WA3M,
  input  logic [3:0]       WA3W,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemtoRegE,
  input  logic             PCSrcD,
  input  logic             PCSrcE,
  input  logic             PCSrcM,
  input  logic             PCSrcW,
  input  logic             BranchTakenE,
  input  logic             HaltD,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic             FlushE,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] stall_count,
  output pcu_state_t       state_o
);

  localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  pcu_state_t       state_q, state_d;
  logic [DCW-1:0]   drain_q, drain_d;
  logic [3:0]       ra1e_q, ra1e_d;
  logic [3:0]       ra2e_q, ra2e_d;
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic ldr_stall;
  logic pc_wr_pend;
  logic fwd_en;

  assign ldr_stall  = MemtoRegE && ((WA3E == RA1D) || (WA3E == RA2D));
  assign pc_wr_pend = PCSrcD | PCSrcE | PCSrcM;
  assign fwd_en     = (state_q == RUN) || (state_q == DRAIN);

  // Next state plus segment-register controls; outside RUN/DRAIN everything is held and bubbled.
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    StallF  = 1'b1;
    StallD  = 1'b1;
    FlushD  = 1'b1;
    FlushE  = 1'b1;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) state_d = RUN;
      end
      RUN: begin
        StallF = ldr_stall | pc_wr_pend;
        StallD = ldr_stall;
        FlushD = pc_wr_pend | PCSrcW | BranchTakenE;
        FlushE = ldr_stall | BranchTakenE;
        // A halt only counts once it is really leaving ID.
        if (HaltD && !StallD && !FlushD) begin
          state_d = DRAIN;
          drain_d = DCW'(DRAIN_CYCLES - 1);
        end
      end
      DRAIN: begin
        StallD = 1'b0;
        FlushE = 1'b0;
        if (drain_q == '0) begin
          state_d = DONE;
        end else begin
          drain_d = drain_q - DCW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ID->EX source addresses; a flush inserts a bubble, which takes priority over the hold.
  always_comb begin
    ra1e_d = ra1e_q;
    ra2e_d = ra2e_q;
    if (FlushE) begin
      ra1e_d = '0;
      ra2e_d = '0;
    end else if (!StallD) begin
      ra1e_d = RA1D;
      ra2e_d = RA2D;
    end
  end

  always_comb begin
    cycle_cnt_d = cycle_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (start && ((state_q == IDLE) || (state_q == DONE))) begin
      cycle_cnt_d = '0;
      stall_cnt_d = '0;
    end else if (fwd_en) begin
      if (cycle_cnt_q != '1) cycle_cnt_d = cycle_cnt_q + CNT_ONE;
      if ((state_q == RUN) && ldr_stall && (stall_cnt_q != '1)) begin
        stall_cnt_d = stall_cnt_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      drain_q     <= '0;
      ra1e_q      <= '0;
      ra2e_q      <= '0;
      cycle_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      drain_q     <= drain_d;
      ra1e_q      <= ra1e_d;
      ra2e_q      <= ra2e_d;
      cycle_cnt_q <= cycle_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  hazard_fwd_cmp u_fwd_a (
    .en_i          (fwd_en),
    .ra_e_i        (ra1e_q),
    .wa3_m_i       (WA3M),
    .wa3_w_i       (WA3W),
    .reg_write_m_i (RegWriteM),
    .reg_write_w_i (RegWriteW),
    .fwd_o         (ForwardAE)
  );

  hazard_fwd_cmp u_fwd_b (
    .en_i          (fwd_en),
    .ra_e_i        (ra2e_q),
    .wa3_m_i       (WA3M),
    .wa3_w_i       (WA3W),
    .reg_write_m_i (RegWriteM),
    .reg_write_w_i (RegWriteW),
    .fwd_o         (ForwardBE)
  );

  assign busy        = fwd_en;
  assign done        = (state_q == DONE);
  assign cycle_count = cycle_cnt_q;
  assign stall_count = stall_cnt_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_pipeline_control_unit.sv
// Bench for pipeline_control_unit: directed scenarios plus a randomized RUN phase, all checked
// against a phase/queue-level reference model of the run sequencing and hazard rules.
module tb_pipeline_control_unit;
  import pipeline_pkg::*;

  localparam int CNT_W        = 32;
  localparam int DRAIN_CYCLES = 3;
  localparam longint MAXC     = (64'd1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset, start;
  logic [3:0]       RA1D, RA2D, WA3E, WA3M, WA3W;
  logic             RegWriteM, RegWriteW, MemtoRegE;
  logic             PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE, HaltD;
  logic [1:0]       ForwardAE, ForwardBE;
  logic             StallF, StallD, FlushD, FlushE, busy, done;
  logic [CNT_W-1:0] cycle_count, stall_count;
  pcu_state_t       state_o;
  logic [9:0]       dut_outs;

  int n_cmp;
  int n_fail;

  // Reference model: run phase 0 idle, 1 run, 2 drain, 3 done; m_left = drain cycles still owed.
  int         m_phase;
  int         m_left;
  logic [3:0] m_ra1e, m_ra2e;
  longint     m_cyc, m_stl;

  always #5 clk = ~clk;

  assign dut_outs = {ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE, busy, done};

  pipeline_control_unit #(.CNT_W(CNT_W), .DRAIN_CYCLES(DRAIN_CYCLES)) dut (
    .clk(clk), .reset(reset), .start(start),
    .RA1D(RA1D), .RA2D(RA2D), .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemtoRegE(MemtoRegE),
    .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM), .PCSrcW(PCSrcW),
    .BranchTakenE(BranchTakenE), .HaltD(HaltD),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .busy(busy), .done(done), .cycle_count(cycle_count), .stall_count(stall_count),
    .state_o(state_o)
  );

  function automatic logic [1:0] ref_fwd(input logic [3:0] ra);
    if (ra == 4'hF) return 2'b00;
    if (RegWriteM && WA3M == ra) return 2'b10;
    if (RegWriteW && WA3W == ra) return 2'b01;
    return 2'b00;
  endfunction

  // {ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE, busy, done}
  function automatic logic [9:0] ref_outs();
    logic ldr, pcw;
    ldr = MemtoRegE && (WA3E == RA1D || WA3E == RA2D);
    pcw = PCSrcD | PCSrcE | PCSrcM;
    case (m_phase)
      1: return {ref_fwd(m_ra1e), ref_fwd(m_ra2e), ldr | pcw, ldr,
                 pcw | PCSrcW | BranchTakenE, ldr | BranchTakenE, 1'b1, 1'b0};
      2: return {ref_fwd(m_ra1e), ref_fwd(m_ra2e), 4'b1010, 2'b10};
      3: return {4'b0000, 4'b1111, 2'b01};
      default: return {4'b0000, 4'b1111, 2'b00};
    endcase
  endfunction

  function automatic pcu_state_t ref_state();
    case (m_phase)
      1: return RUN;
      2: return DRAIN;
      3: return DONE;
      default: return IDLE;
    endcase
  endfunction

  task automatic model_edge();
    logic [9:0] o;
    logic ldr;
    o   = ref_outs();
    ldr = MemtoRegE && (WA3E == RA1D || WA3E == RA2D);
    if (reset) begin
      m_phase = 0; m_left = 0; m_ra1e = 0; m_ra2e = 0; m_cyc = 0; m_stl = 0;
      return;
    end
    if (o[2]) begin
      m_ra1e = 0; m_ra2e = 0;
    end else if (!o[4]) begin
      m_ra1e = RA1D; m_ra2e = RA2D;
    end
    case (m_phase)
      0, 3: if (start) begin m_phase = 1; m_cyc = 0; m_stl = 0; end
      1: begin
        if (m_cyc < MAXC) m_cyc++;
        if (ldr && m_stl < MAXC) m_stl++;
        if (HaltD && !o[4] && !o[3]) begin m_phase = 2; m_left = DRAIN_CYCLES; end
      end
      2: begin
        if (m_cyc < MAXC) m_cyc++;
        m_left--;
        if (m_left == 0) m_phase = 3;
      end
      default: m_phase = 0;
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic clear_inputs();
    RA1D = 0; RA2D = 0; WA3E = 0; WA3M = 0; WA3W = 0;
    RegWriteM = 0; RegWriteW = 0; MemtoRegE = 0;
    PCSrcD = 0; PCSrcE = 0; PCSrcM = 0; PCSrcW = 0; BranchTakenE = 0; HaltD = 0;
  endtask

  task automatic test_reset();
    reset = 1; start = 0; clear_inputs();
    tick();
    reset = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_cmp++;
      if (state_o !== ref_state() || dut_outs !== 10'b0000_1111_00) begin
        n_fail++;
        $display("FAIL reset_idle cyc %0d: got state %0d outs %b, exp state %0d outs %b",
                 i, state_o, dut_outs, ref_state(), 10'b0000_1111_00);
      end
      n_cmp++;
      if (cycle_count !== 0 || stall_count !== 0) begin
        n_fail++;
        $display("FAIL reset_counts: got %0d/%0d exp 0/0", cycle_count, stall_count);
      end
    end
  endtask

  task automatic test_forwarding();
    clear_inputs();
    start = 1; tick(); start = 0;
    n_cmp++;
    if (state_o !== ref_state() || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL start_run: got state %0d busy %b exp state %0d busy 1", state_o, busy, ref_state());
    end
    RA1D = 3; RA2D = 7; tick();
    WA3M = 3; RegWriteM = 1; WA3W = 3; RegWriteW = 1; #1;
    n_cmp++;
    if (ForwardAE !== 2'b10 || dut_outs !== ref_outs()) begin
      n_fail++;
      $display("FAIL fwd_mem_wins: got %b outs %b exp 10 outs %b", ForwardAE, dut_outs, ref_outs());
    end
    RegWriteM = 0; #1;
    n_cmp++;
    if (ForwardAE !== 2'b01 || dut_outs !== ref_outs()) begin
      n_fail++;
      $display("FAIL fwd_wb: got %b outs %b exp 01 outs %b", ForwardAE, dut_outs, ref_outs());
    end
    WA3M = 7; RegWriteM = 1; #1;
    n_cmp++;
    if (ForwardBE !== 2'b10 || ForwardAE !== 2'b01) begin
      n_fail++;
      $display("FAIL fwd_split: got A=%b B=%b exp A=01 B=10", ForwardAE, ForwardBE);
    end
    RA1D = 15; WA3M = 15; WA3W = 15; tick(); #1;
    n_cmp++;
    if (ForwardAE !== 2'b00 || dut_outs !== ref_outs()) begin
      n_fail++;
      $display("FAIL fwd_pc_never: got %b outs %b exp 00 outs %b", ForwardAE, dut_outs, ref_outs());
    end
  endtask

  task automatic test_load_use();
    longint stl_before;
    clear_inputs(); tick();
    stl_before = m_stl;
    MemtoRegE = 1; WA3E = 5; RA2D = 5; RA1D = 2; #1;
    n_cmp++;
    if ({StallF, StallD, FlushE} !== 3'b111 || dut_outs !== ref_outs()) begin
      n_fail++;
      $display("FAIL ldr_stall: got outs %b exp outs %b", dut_outs, ref_outs());
    end
    tick();
    MemtoRegE = 0; #1;
    n_cmp++;
    if (stall_count !== CNT_W'(stl_before + 1) || {StallF, StallD, FlushE} !== 3'b000) begin
      n_fail++;
      $display("FAIL ldr_count: got cnt %0d s %b exp cnt %0d s 000",
               stall_count, {StallF, StallD, FlushE}, stl_before + 1);
    end
  endtask

  task automatic test_control_hazard();
    int n_sf, n_fd;
    n_sf = 0; n_fd = 0;
    clear_inputs();
    for (int k = 0; k < 5; k++) begin
      {PCSrcD, PCSrcE, PCSrcM, PCSrcW} = (k < 4) ? (4'b1000 >> k) : 4'b0000;
      #1;
      n_cmp++;
      if (dut_outs !== ref_outs()) begin
        n_fail++;
        $display("FAIL pc_write step %0d: got %b exp %b", k, dut_outs, ref_outs());
      end
      n_sf += int'(StallF);
      n_fd += int'(FlushD);
      tick();
    end
    n_cmp++;
    if (n_sf != 3 || n_fd != 4) begin
      n_fail++;
      $display("FAIL pc_write_len: got StallF %0d FlushD %0d cycles exp 3 and 4", n_sf, n_fd);
    end
    clear_inputs();
    BranchTakenE = 1; #1;
    n_cmp++;
    if ({FlushD, FlushE} !== 2'b11 || dut_outs !== ref_outs()) begin
      n_fail++;
      $display("FAIL branch_flush: got %b exp %b", dut_outs, ref_outs());
    end
    MemtoRegE = 1; WA3E = 4; RA1D = 4; #1;
    n_cmp++;
    if ({StallD, FlushD, FlushE} !== 3'b111 || dut_outs !== ref_outs()) begin
      n_fail++;
      $display("FAIL branch_plus_ldr: got %b exp %b", dut_outs, ref_outs());
    end
    tick(); clear_inputs();
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      RA1D = ($urandom_range(0, 5) == 0) ? 4'hF : 4'($urandom_range(0, 3));
      RA2D = 4'($urandom_range(0, 3));
      WA3E = 4'($urandom_range(0, 3));
      WA3M = ($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom_range(0, 3));
      WA3W = 4'($urandom_range(0, 3));
      RegWriteM = 1'($urandom_range(0, 1));
      RegWriteW = 1'($urandom_range(0, 1));
      MemtoRegE = ($urandom_range(0, 3) == 0);
      PCSrcD = ($urandom_range(0, 7) == 0);
      PCSrcE = ($urandom_range(0, 7) == 0);
      PCSrcM = ($urandom_range(0, 7) == 0);
      PCSrcW = ($urandom_range(0, 7) == 0);
      BranchTakenE = ($urandom_range(0, 7) == 0);
      start = ($urandom_range(0, 15) == 0);
      HaltD = 0;
      #1;
      n_cmp++;
      if (dut_outs !== ref_outs() || state_o !== ref_state()) begin
        n_fail++;
        $display("FAIL rand_outs cyc %0d: got %b st %0d exp %b st %0d",
                 i, dut_outs, state_o, ref_outs(), ref_state());
      end
      n_cmp++;
      if (cycle_count !== CNT_W'(m_cyc) || stall_count !== CNT_W'(m_stl)) begin
        n_fail++;
        $display("FAIL rand_counts cyc %0d: got %0d/%0d exp %0d/%0d",
                 i, cycle_count, stall_count, m_cyc, m_stl);
      end
      tick();
    end
    start = 0; clear_inputs();
  endtask

  task automatic test_halt_restart();
    clear_inputs();
    MemtoRegE = 1; WA3E = 1; RA1D = 1; HaltD = 1; tick();
    MemtoRegE = 0; PCSrcW = 1; tick();
    clear_inputs(); #1;
    n_cmp++;
    if (state_o !== RUN || ref_state() !== RUN) begin
      n_fail++;
      $display("FAIL halt_blocked: got state %0d exp %0d", state_o, RUN);
    end
    HaltD = 1; tick(); HaltD = 0;
    for (int i = 0; i < DRAIN_CYCLES; i++) tick();
    n_cmp++;
    if (state_o !== ref_state() || done !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL halt_done: got st %0d done %b busy %b exp st %0d done 1 busy 0",
               state_o, done, busy, ref_state());
    end
    start = 1; tick(); start = 0;
    n_cmp++;
    if (cycle_count !== 0 || stall_count !== 0 || done !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL restart: got cnt %0d/%0d done %b busy %b exp 0/0 done 0 busy 1",
               cycle_count, stall_count, done, busy);
    end
    for (int i = 0; i < 19; i++) tick();
    n_cmp++;
    if (cycle_count !== 19) begin
      n_fail++;
      $display("FAIL run_len: got %0d exp 19", cycle_count);
    end
    HaltD = 1; tick(); HaltD = 0;
    n_cmp++;
    if (state_o !== DRAIN || cycle_count !== 20 || dut_outs !== ref_outs()) begin
      n_fail++;
      $display("FAIL drain_entry: got st %0d cnt %0d outs %b exp st %0d cnt 20 outs %b",
               state_o, cycle_count, dut_outs, DRAIN, ref_outs());
    end
    tick(); tick();
    n_cmp++;
    if (state_o !== DRAIN || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL drain_hold: got st %0d busy %b exp st %0d busy 1", state_o, busy, DRAIN);
    end
    tick();
    n_cmp++;
    if (done !== 1'b1 || busy !== 1'b0 || cycle_count !== 23 || CNT_W'(m_cyc) !== cycle_count) begin
      n_fail++;
      $display("FAIL drain_done: got done %b busy %b cnt %0d exp done 1 busy 0 cnt 23",
               done, busy, cycle_count);
    end
    for (int i = 0; i < 3; i++) begin
      MemtoRegE = 1'($urandom_range(0, 1)); HaltD = 1'($urandom_range(0, 1));
      tick();
    end
    clear_inputs(); #1;
    n_cmp++;
    if (cycle_count !== 23 || done !== 1'b1 || dut_outs !== ref_outs()) begin
      n_fail++;
      $display("FAIL done_frozen: got cnt %0d done %b exp cnt 23 done 1", cycle_count, done);
    end
    start = 1; tick(); start = 0;
    n_cmp++;
    if (done !== 1'b0 || cycle_count !== 0 || stall_count !== 0 || state_o !== RUN) begin
      n_fail++;
      $display("FAIL restart_after_done: got done %b cnt %0d/%0d st %0d exp 0 0/0 st %0d",
               done, cycle_count, stall_count, state_o, RUN);
    end
  endtask

  task automatic test_reset_in_drain();
    clear_inputs();
    tick(); tick();
    HaltD = 1; tick(); HaltD = 0;
    tick();
    n_cmp++;
    if (state_o !== DRAIN || ref_state() !== DRAIN) begin
      n_fail++;
      $display("FAIL drain_second: got st %0d exp st %0d", state_o, DRAIN);
    end
    reset = 1; tick(); reset = 0;
    n_cmp++;
    if (state_o !== IDLE || done !== 1'b0 || cycle_count !== 0 || stall_count !== 0 ||
        dut_outs !== 10'b0000_1111_00) begin
      n_fail++;
      $display("FAIL reset_mid_drain: got st %0d done %b cnt %0d/%0d outs %b exp idle 0 0/0 0000111100",
               state_o, done, cycle_count, stall_count, dut_outs);
    end
    tick(); tick();
    n_cmp++;
    if (state_o !== ref_state() || done !== 1'b0 || dut_outs !== ref_outs()) begin
      n_fail++;
      $display("FAIL reset_no_partial: got st %0d done %b outs %b exp st %0d done 0 outs %b",
               state_o, done, dut_outs, ref_state(), ref_outs());
    end
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    m_phase = 0; m_left = 0; m_ra1e = 0; m_ra2e = 0; m_cyc = 0; m_stl = 0;
    reset = 1; start = 0; clear_inputs();
    test_reset();
    test_forwarding();
    test_load_use();
    test_control_hazard();
    test_random();
    test_halt_restart();
    test_reset_in_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before the summary");
    $fatal(1, "watchdog expired");
  end

endmodule
